// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Encoding of the sub input.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Number of digits in one operand.
  function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // Digit counter width: clog2(NDIG), never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
    int unsigned w;
    w = $clog2(width / digit);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// DIGIT-bit ripple-carry slice built from 1-bit full adders.
module digit_adder #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] c;

  // Ripple the carry through one full adder per bit.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    cout = c[DIGIT];
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor with valid/ready handshakes on both sides.
// Processes DIGIT bits per cycle, LSB digit first; result after WIDTH/DIGIT cycles.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
  localparam int unsigned CW   = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_adder: WIDTH must be at least 2");
  end
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_adder: DIGIT must divide WIDTH exactly");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cy_q, cy_d;
  logic              amsb_q, amsb_d;
  logic              bmsb_q, bmsb_d;
  logic              ovf_q, ovf_d;

  logic [DIGIT-1:0]  slice_s;
  logic              slice_cout;
  logic [WIDTH-1:0]  sum_shift;

  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .x    (a_q[DIGIT-1:0]),
    .y    (b_q[DIGIT-1:0]),
    .cin  (cy_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // New digit enters the sum register at the MSB end; full-width digit replaces it.
  if (DIGIT == WIDTH) begin : g_shift_full
    assign sum_shift = slice_s;
  end else begin : g_shift_part
    assign sum_shift = {slice_s, sum_q[WIDTH-1:DIGIT]};
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = (sub == MODE_SUB) ? ~b : b;
          cy_d    = sub;
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b_d[WIDTH-1];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        sum_d = sum_shift;
        cy_d  = slice_cout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Overflow is registered on entry to DONE so it stays stable with sum.
          ovf_d   = (amsb_q == bmsb_q) && (sum_shift[WIDTH-1] != amsb_q);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign carry     = cy_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, digit-serial adder/subtractor; next generation of the team's 4-bit ripple adder.
- Generalised in width, digits processed per cycle, and add/sub mode.
- Adds signed-overflow detection and valid/ready handshakes on input and output.
- Sits between an operand producer and a result consumer in the datapath.
- Trades latency (WIDTH/DIGIT cycles) for one small DIGIT-bit adder slice.

Parameters:
- WIDTH, 8, operand/result width in bits; WIDTH >= 2.
- DIGIT, 2, bits added per cycle; must divide WIDTH exactly (elaboration error otherwise).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A, two's complement or unsigned.
- b  in  WIDTH  operand B.
- sub  in  1  0: A+B; 1: A-B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, registered.
- carry  out  1  unsigned carry-out; for sub, 1 means no borrow.
- overflow  out  1  signed overflow.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: in_ready=1; out_valid=0; busy=0; sum=0; carry=0; overflow=0; state=IDLE; digit counter=0.
- Reset asserted mid-operation aborts the operation immediately; no result is produced.
- Derived constant: NDIG = WIDTH/DIGIT; counter width = clog2(NDIG), minimum 1.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch A; latch B_eff = sub ? ~b : b; carry register = sub; latch a[WIDTH-1] and B_eff[WIDTH-1]; counter=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: add DIGIT LSBs of A shift reg + DIGIT LSBs of B_eff shift reg + carry register.
  - Shift both operands right by DIGIT.
  - Shift the DIGIT-bit result into the sum register from the MSB end.
  - Carry register takes the slice carry-out.
  - Counter increments; after the cycle with counter==NDIG-1, go to DONE.
- DONE:
  - out_valid=1; sum, carry and overflow stable until handshake.
  - carry = final carry register.
  - overflow = (latched A msb == latched B_eff msb) && (sum msb != latched A msb).
  - On out_valid&&out_ready: go to IDLE, out_valid=0.
- Latency: operands accepted at edge k gives out_valid high after edge k+NDIG. With out_ready held high, throughput is one result per NDIG+2 cycles.
- in_valid is ignored outside IDLE; operand inputs are not sampled after acceptance.
- DIGIT==WIDTH: single RUN cycle, latency 1.
- sum contents are only meaningful while out_valid=1; the last value is held after return to IDLE.
- No combinational path from in_valid or out_ready to any output.

Decomposition:
- Shared package serial_adder_pkg holds:
  - State enum (IDLE, RUN, DONE).
  - NDIG/counter-width helper function.
  - Add/sub mode encoding constants.
- One natural sub-module: digit_adder.
  - Combinational, parametrised by DIGIT.
  - Inputs: x, y, cin. Outputs: s, cout. Ripple of 1-bit full adders.
  - Instantiated once in the RUN datapath.

Test Plan:
- WIDTH=8, DIGIT=2, sub=0, a=0x0F, b=0x01 -> sum=0x10, carry=0, overflow=0; out_valid rises exactly 4 cycles after acceptance.
- sub=0: 0xFF+0x01 -> sum=0x00, carry=1, overflow=0. 0x7F+0x01 -> sum=0x80, carry=0, overflow=1.
- sub=1: 0x05-0x07 -> sum=0xFE, carry=0, overflow=0. 0x80-0x01 -> sum=0x7F, carry=1, overflow=1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a/b -> sum/carry/overflow stable, in_ready=0, no second acceptance; the next accept only occurs after the out handshake.
- Reset mid-RUN: assert rst_n=0 asynchronously after 2 RUN cycles -> outputs reach reset values without a clock edge, in_ready=1 after release. A following 0x12+0x34 gives 0x46.
- Parameter sweep: WIDTH=16 with DIGIT=1, 4 and 16; random operands and modes checked against a reference model; latency equals WIDTH/DIGIT in every case.
